// File: rtl/elixirchip_es1_spu_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_ctl_pkg
// Brief    : Shared tag type and round-robin search helper for the SPU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package elixirchip_es1_spu_ctl_pkg;

  localparam int c_MAX_REQ = 16;
  localparam int c_IDX_W   = 4;

  typedef struct packed {
    logic               valid;
    logic [c_IDX_W-1:0] idx;
  } spu_tag_t;

  // Returns {found, index} of the first set bit of elig at or after ptr, wrapping modulo n.
  function automatic logic [c_IDX_W:0] rr_next_idx(
    input logic [c_MAX_REQ-1:0] elig,
    input logic [c_IDX_W-1:0]   ptr,
    input int                   n
  );
    logic [c_IDX_W:0] res;
    int               idx;
    res = '0;
    for (int off = c_MAX_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % n;
      if ((off < n) && elig[idx[c_IDX_W-1:0]]) begin
        res = {1'b1, idx[c_IDX_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elixirchip_es1_spu_ctl_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_ctl_tag_pipe
// Brief    : Clock-enabled tag delay line; LATENCY=0 degenerates to a wire.
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_ctl_tag_pipe #(
  parameter int W       = 3,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cke,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag,
  output logic         o_any_valid
);

  generate
    if (LATENCY == 0) begin : g_passthru
      logic w_unused;
      assign w_unused    = ^{clk, rst_n, i_cke};
      assign o_tag       = i_tag;
      assign o_any_valid = 1'b0;
    end else begin : g_pipe
      logic [W-1:0] r_stage [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < LATENCY; s++) r_stage[s] <= '0;
        end else if (i_cke) begin
          r_stage[0] <= i_tag;
          for (int s = 1; s < LATENCY; s++) r_stage[s] <= r_stage[s-1];
        end
      end

      assign o_tag = r_stage[LATENCY-1];

      // Valid bit lives in the MSB of each stage.
      always_comb begin
        o_any_valid = 1'b0;
        for (int s = 0; s < LATENCY; s++) o_any_valid = o_any_valid | r_stage[s][W-1];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/elixirchip_es1_spu_ctl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : elixirchip_es1_spu_ctl_arbiter
// Brief    : Round-robin/lock issue arbiter for a shared fixed-latency SPU pipe.
// Options  : ELIXIRCHIP_ES1_SPU_CTL_ARBITER_STATS_EN adds grant/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module elixirchip_es1_spu_ctl_arbiter
  import elixirchip_es1_spu_ctl_pkg::*;
#(
  parameter int    N_REQ           = 4,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 4,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cke,
  input  logic [N_REQ-1:0]         s_req,
  input  logic [N_REQ-1:0]         s_lock,
  output logic [N_REQ-1:0]         s_grant,
  output logic                     m_valid,
  output logic [$clog2(N_REQ)-1:0] m_sel,
  output logic [N_REQ-1:0]         r_valid,
  output logic                     busy
`ifdef ELIXIRCHIP_ES1_SPU_CTL_ARBITER_STATS_EN
  ,
  output logic [N_REQ*32-1:0]      stat_grant_count,
  output logic [31:0]              stat_stall_count
`endif
);

  localparam int                 c_SEL_W   = $clog2(N_REQ);
  localparam int                 c_TAG_W   = 1 + c_SEL_W;
  localparam int                 c_CNT_W   = 4;
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

  generate
    if ((N_REQ < 2) || (N_REQ > c_MAX_REQ)) begin : g_bad_n_req
      $error("N_REQ must be in 2..16");
    end
    if (LATENCY < 0) begin : g_bad_latency
      $error("LATENCY must be >= 0");
    end
    if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 15)) begin : g_bad_max_out
      $error("MAX_OUTSTANDING must be in 1..15");
    end
    if ((DEVICE == "") || ((SIMULATION != "false") && (SIMULATION != "true"))
        || ((DEBUG != "false") && (DEBUG != "true"))) begin : g_bad_strings
      $error("DEVICE must be non-empty; SIMULATION/DEBUG must be true or false");
    end
  endgenerate

  logic [N_REQ-1:0]   r_grant;
  logic               r_m_valid;
  logic [c_SEL_W-1:0] r_m_sel;
  logic [c_SEL_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_cnt [N_REQ];

  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_gnt_onehot;
  logic [N_REQ-1:0]   w_dec;
  logic [c_IDX_W:0]   w_rr;
  logic               w_rr_unused;
  logic               w_lock_hit;
  logic               w_gnt_vld;
  logic [c_SEL_W-1:0] w_gnt_idx;
  logic [c_SEL_W-1:0] w_ptr_nxt;
  logic [c_TAG_W-1:0] w_pipe_in;
  logic [c_TAG_W-1:0] w_pipe_out;
  logic               w_pipe_busy;
  spu_tag_t           w_tag_out;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) w_elig[i] = s_req[i] && (r_cnt[i] < c_MAX_CNT);
  end

  assign w_rr        = rr_next_idx(c_MAX_REQ'(w_elig), c_IDX_W'(r_ptr), N_REQ);
  assign w_rr_unused = ^w_rr;

  // The last-granted requester is the lock owner; it keeps the slot while locked and eligible.
  assign w_lock_hit = r_m_valid && s_lock[r_m_sel] && w_elig[r_m_sel];
  assign w_gnt_vld  = w_lock_hit || w_rr[c_IDX_W];
  assign w_gnt_idx  = w_lock_hit ? r_m_sel : w_rr[c_SEL_W-1:0];
  assign w_ptr_nxt  = (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + c_SEL_W'(1);

  always_comb begin
    w_gnt_onehot = '0;
    w_dec        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_onehot[i] = w_gnt_vld && (w_gnt_idx == c_SEL_W'(i));
      w_dec[i]        = r_valid[i] && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant   <= '0;
      r_m_valid <= 1'b0;
      r_m_sel   <= '0;
      r_ptr     <= '0;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else if (cke) begin
      r_grant   <= w_gnt_onehot;
      r_m_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_m_sel <= w_gnt_idx;
        r_ptr   <= w_ptr_nxt;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (w_gnt_onehot[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
        end else if (!w_gnt_onehot[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - c_CNT_W'(1);
        end
      end
    end
  end

  assign w_pipe_in = {r_m_valid, r_m_sel};

  elixirchip_es1_spu_ctl_tag_pipe #(
    .W       (c_TAG_W),
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_cke       (cke),
    .i_tag       (w_pipe_in),
    .o_tag       (w_pipe_out),
    .o_any_valid (w_pipe_busy)
  );

  assign w_tag_out.valid = w_pipe_out[c_TAG_W-1];
  assign w_tag_out.idx   = c_IDX_W'(w_pipe_out[c_SEL_W-1:0]);

  always_comb begin
    r_valid = '0;
    for (int i = 0; i < N_REQ; i++) r_valid[i] = w_tag_out.valid && (w_tag_out.idx == c_IDX_W'(i));
  end

  assign s_grant = r_grant;
  assign m_valid = r_m_valid;
  assign m_sel   = r_m_sel;
  assign busy    = w_pipe_busy | r_m_valid;

`ifdef ELIXIRCHIP_ES1_SPU_CTL_ARBITER_STATS_EN
  logic [31:0] r_stat_grant [N_REQ];
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) r_stat_grant[i] <= '0;
      r_stat_stall <= '0;
    end else if (cke) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_gnt_onehot[i]) r_stat_grant[i] <= r_stat_grant[i] + 32'd1;
      end
      if ((|s_req) && !w_gnt_vld) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_out
    assign stat_grant_count[gi*32 +: 32] = r_stat_grant[gi];
  end
  assign stat_stall_count = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: doc/elixirchip_es1_spu_ctl_arbiter.md
ELIXIRCHIP_ES1_SPU_CTL_ARBITER -- requirements
Module: elixirchip_es1_spu_ctl_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one SPU pipeline (2..16).
REQ-002 SHALL have parameter LATENCY, default 1, fixed SPU pipeline depth in cke-qualified cycles (>=0).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, per-requester in-flight limit (1..15).
REQ-004 SHALL have parameters DEVICE "RTL", SIMULATION "false", DEBUG "false", no functional effect.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cke  input  1  clock enable; all state holds when low.
REQ-008 s_req  input  N_REQ  per-requester issue request.
REQ-009 s_lock  input  N_REQ  per-requester hold-grant request for back-to-back issue.
REQ-010 s_grant  output  N_REQ  one-hot issue acknowledge, registered.
REQ-011 m_valid  output  1  issue strobe to the shared SPU input stage.
REQ-012 m_sel  output  $clog2(N_REQ)  index of the granted requester, valid when m_valid=1.
REQ-013 r_valid  output  N_REQ  one-hot result strobe, LATENCY cycles after m_valid.
REQ-014 busy  output  1  high while any issue is in flight.

Function
REQ-015 Arbitration: round-robin over eligible requesters; eligible = s_req[i] & (outstanding[i] < MAX_OUTSTANDING).
REQ-016 Priority pointer SHALL start at index 0 and move to (granted index + 1) mod N_REQ after each grant.
REQ-017 s_grant, m_valid, m_sel SHALL be registered: requests sampled at edge k produce grant at edge k (visible cycle k+1), at most one grant per cke cycle.
REQ-018 Lock: if granted requester i has s_lock[i]=1 and remains eligible, it SHALL be granted again next cycle, overriding round-robin; lock releases when s_lock[i]=0 or i becomes ineligible.
REQ-019 A 1+$clog2(N_REQ)-bit tag (valid,index) SHALL enter a LATENCY-stage pipeline on each cke cycle; r_valid = one-hot decode of the tag at stage LATENCY.
REQ-020 LATENCY=0: r_valid SHALL equal the decode of m_valid/m_sel combinationally.
REQ-021 outstanding[i] SHALL increment on grant to i, decrement on r_valid[i]; simultaneous increment and decrement SHALL leave it unchanged.
REQ-022 outstanding[i] SHALL never exceed MAX_OUTSTANDING nor underflow; a requester at the limit receives no grant even when locked.
REQ-023 cke=0: pointer, counters, tag pipeline, outputs all hold; no new grant.
REQ-024 No eligible requester: m_valid=0, s_grant=0, pointer unchanged.
REQ-025 busy = OR of all tag-pipeline valid bits and m_valid.

Reset
REQ-026 reset_n low SHALL asynchronously clear s_grant, m_valid, m_sel, r_valid, busy, pointer, counters, tag pipeline, lock owner.
REQ-027 Reset mid-operation SHALL discard in-flight tags; no r_valid after release until new grants propagate.
REQ-028 First grant possible on the first cke edge after reset_n deassertion.

Configuration
REQ-029 Macro ELIXIRCHIP_ES1_SPU_CTL_ARBITER_STATS_EN defined: add output stat_grant_count (N_REQ x 32, wrapping per-requester grant counters) and stat_stall_count (32, cycles with s_req!=0 but no grant), reset to 0.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package elixirchip_es1_spu_ctl_pkg SHALL hold the tag struct typedef and a function for the round-robin next-index search.
REQ-032 Sub-module elixirchip_es1_spu_ctl_tag_pipe SHALL implement the cke-qualified tag delay line with async active-low reset.
REQ-033 Parameter assertions SHALL reject N_REQ<2, LATENCY<0, MAX_OUTSTANDING<1.

Verification
REQ-034 N_REQ=4, LATENCY=3, all s_req=1 -> grants 0,1,2,3,0... one per cycle; r_valid matches each grant 3 cycles later.
REQ-035 MAX_OUTSTANDING=2, LATENCY=5, only s_req[2]=1 -> two grants, then no grant until r_valid[2], then resume.
REQ-036 s_lock[1]=1 with s_req=4'b1111 after grant to 1 -> consecutive grants to 1 until outstanding reaches limit or s_lock drops, then grant 2.
REQ-037 cke low 3 cycles mid-stream -> outputs and tags frozen; sequence resumes with no lost or duplicated r_valid.
REQ-038 reset_n pulsed low with 3 tags in flight -> all outputs 0 immediately; no r_valid appears afterwards without new grants.
REQ-039 LATENCY=0 -> r_valid equals one-hot(m_sel) in same cycle as m_valid; counters stay at 0 or 1.
